// File: rtl/dsram_pkg.sv
// dsram_pkg: shared types and helpers for the data-side SRAM responder.
//   dsram_state_e  : wait-state FSM states (IDLE/WAIT/DONE)
//   DSRAM_LANES    : byte lanes per 32-bit word
//   dsram_merge    : byte-lane merge of a new word into an old word
//   dsram_in_range : region check of a byte address against a base
package dsram_pkg;
   typedef enum logic [1:0] {IDLE, WAIT, DONE} dsram_state_e;
   localparam int DSRAM_LANES = 4;
   function automatic logic [31:0] dsram_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                               input logic [DSRAM_LANES-1:0] mask);
      logic [31:0] m;
      for (int i = 0; i < DSRAM_LANES; i++) m[8*i+:8] = mask[i] ? new_w[8*i+:8] : old_w[8*i+:8];
      return m;
   endfunction
   function automatic logic dsram_in_range(input logic [31:0] addr, input logic [31:0] base,
                                           input int unsigned addr_w);
      return (addr >> (addr_w + 2)) == (base >> (addr_w + 2));
   endfunction
endpackage

// File: rtl/dsram_array.sv
// dsram_array: 2^ADDR_W x 32 single-port memory, byte-lane writes, registered read port.
//   clk, rst : clock, synchronous active-high reset (clears rdata_o only)
//   en_i     : perform access this cycle
//   wen_i    : byte-lane write mask, 0 means read
//   idx_i    : word index
//   wdata_i  : write data
//   rdata_o  : registered read data, holds between reads
module dsram_array
   import dsram_pkg::*;
#(
   parameter int ADDR_W = 12
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en_i,
   input  logic [DSRAM_LANES-1:0] wen_i,
   input  logic [ADDR_W-1:0]      idx_i,
   input  logic [31:0]            wdata_i,
   output logic [31:0]            rdata_o
);
   logic [31:0] mem_q [2**ADDR_W];
   logic [31:0] rdata_q;
   always_ff @(posedge clk)
      if (en_i && wen_i != '0) mem_q[idx_i] <= dsram_merge(mem_q[idx_i], wdata_i, wen_i);
   always_ff @(posedge clk)
      if (rst) rdata_q <= '0;
      else if (en_i && wen_i == '0) rdata_q <= mem_q[idx_i];
   assign rdata_o = rdata_q;
endmodule

// File: rtl/dsram_responder.sv
// dsram_responder: data SRAM target with range check, error pulse and optional wait states.
//   clk, rst        : clock, synchronous active-high reset
//   data_sram_en    : request valid
//   data_sram_wen   : byte-lane write mask, 0 means read
//   data_sram_addr  : byte address
//   data_sram_wdata : write data
//   data_sram_rdata : registered read data (0 after an out-of-range read)
//   stallreq        : freeze EX and earlier while wait states run
//   err             : one-cycle pulse after an out-of-range access
// Macro DSRAM_WAIT_STATE_EN builds the WAIT_CYCLES wait-state FSM; otherwise
// accesses complete in the acceptance cycle and stallreq is tied low.
module dsram_responder
   import dsram_pkg::*;
#(
   parameter int          ADDR_W      = 12,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          WAIT_CYCLES = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   data_sram_en,
   input  logic [DSRAM_LANES-1:0] data_sram_wen,
   input  logic [31:0]            data_sram_addr,
   input  logic [31:0]            data_sram_wdata,
   output logic [31:0]            data_sram_rdata,
   output logic                   stallreq,
   output logic                   err
);
   logic                   acc_fire;
   logic [31:0]            acc_addr;
   logic [DSRAM_LANES-1:0] acc_wen;
   logic [31:0]            acc_wdata;
   logic                   in_rng;
   logic                   oor_q;
   logic                   err_q;
   logic [31:0]            arr_rdata;
   logic                   unused_ok;
`ifdef DSRAM_WAIT_STATE_EN
   localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
   dsram_state_e           state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [31:0]            addr_q, wdata_q;
   logic [DSRAM_LANES-1:0] wen_q;
   logic                   stall;
   always_ff @(posedge clk)
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   always_ff @(posedge clk)
      if (state_q == IDLE && data_sram_en) begin
         addr_q  <= data_sram_addr;
         wen_q   <= data_sram_wen;
         wdata_q <= data_sram_wdata;
      end
   // DONE ignores the inputs: the request still held there is the one just served.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      stall   = 1'b0;
      case (state_q)
         IDLE: if (data_sram_en) begin
            state_d = WAIT;
            cnt_d   = CNT_W'(WAIT_CYCLES);
            stall   = 1'b1;
         end
         WAIT: begin
            stall   = 1'b1;
            cnt_d   = cnt_q - 1'b1;
            state_d = cnt_q == CNT_W'(1) ? DONE : WAIT;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   assign acc_fire  = state_q == WAIT && cnt_q == CNT_W'(1) && !rst;
   assign acc_addr  = addr_q;
   assign acc_wen   = wen_q;
   assign acc_wdata = wdata_q;
   assign stallreq  = stall && !rst;
   assign unused_ok = ^acc_addr[1:0];
`else
   assign acc_fire  = data_sram_en && !rst;
   assign acc_addr  = data_sram_addr;
   assign acc_wen   = data_sram_wen;
   assign acc_wdata = data_sram_wdata;
   assign stallreq  = 1'b0;
   assign unused_ok = ^{acc_addr[1:0], WAIT_CYCLES[0]};
`endif
   assign in_rng = dsram_in_range(acc_addr, BASE_ADDR, ADDR_W);
   // The array only updates rdata on in-range reads; oor_q masks it to 0 after an out-of-range read.
   always_ff @(posedge clk)
      if (rst) begin
         oor_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         oor_q <= acc_fire && acc_wen == '0 ? !in_rng : oor_q;
         err_q <= acc_fire && !in_rng;
      end
   dsram_array #(.ADDR_W(ADDR_W)) u_array (
      .clk     (clk),
      .rst     (rst),
      .en_i    (acc_fire && in_rng),
      .wen_i   (acc_wen),
      .idx_i   (acc_addr[ADDR_W+1:2]),
      .wdata_i (acc_wdata),
      .rdata_o (arr_rdata)
   );
   assign data_sram_rdata = oor_q ? '0 : arr_rdata;
   assign err             = err_q;
endmodule

// File: tb/tb_dsram_responder.sv
// tb_dsram_responder: scoreboard bench for dsram_responder in either build.
module tb_dsram_responder;
   localparam int          ADDR_W = 12;
   localparam logic [31:0] BASE   = 32'h0000_0000;
   localparam int          WAITC  = 2;
   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } exp_t;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic [3:0]  wen = '0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic        stallreq;
   logic        err;
   int          n_chk = 0;
   int          n_err = 0;
   exp_t        sb_q [$];
   logic [31:0] model [int];
   logic [31:0] last_rdata = '0;
   always #5 clk = ~clk;
   dsram_responder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .WAIT_CYCLES(WAITC)) dut (
      .clk             (clk),
      .rst             (rst),
      .data_sram_en    (en),
      .data_sram_wen   (wen),
      .data_sram_addr  (addr),
      .data_sram_wdata (wdata),
      .data_sram_rdata (rdata),
      .stallreq        (stallreq),
      .err             (err)
   );
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   function automatic exp_t predict(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
      exp_t e;
      logic in_r;
      int   k;
      in_r = (a >> (ADDR_W + 2)) == (BASE >> (ADDR_W + 2));
      k    = int'(a[ADDR_W+1:2]);
      if (w != 4'h0 && in_r) begin
         logic [31:0] old_w;
         old_w = model.exists(k) ? model[k] : 32'h0;
         for (int i = 0; i < 4; i++) if (w[i]) old_w[8*i+:8] = d[8*i+:8];
         model[k] = old_w;
      end
      if (w == 4'h0) last_rdata = in_r ? model[k] : 32'h0;
      e.rdata = last_rdata;
      e.err   = !in_r;
      return e;
   endfunction
   task automatic compare_out(input string tag);
      exp_t e;
      if (sb_q.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd0, 32'd1);
         return;
      end
      e = sb_q.pop_front();
      chk({tag, "_rdata"}, rdata, e.rdata);
      chk({tag, "_err"}, {31'd0, err}, {31'd0, e.err});
   endtask
   // Called at #1 after a posedge; returns at #1 after a later posedge.
   task automatic access(input string tag, input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
      sb_q.push_back(predict(a, w, d));
      en    = 1'b1;
      addr  = a;
      wen   = w;
      wdata = d;
`ifdef DSRAM_WAIT_STATE_EN
      for (int k = 0; k <= WAITC; k++) begin
         @(negedge clk);
         chk({tag, "_stall_hi"}, {31'd0, stallreq}, 32'd1);
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      chk({tag, "_stall_done"}, {31'd0, stallreq}, 32'd0);
      compare_out(tag);
      @(posedge clk);
      #1;
      en = 1'b0;
`else
      @(negedge clk);
      chk({tag, "_stall_lo"}, {31'd0, stallreq}, 32'd0);
      @(posedge clk);
      #1;
      en = 1'b0;
      @(negedge clk);
      compare_out(tag);
      @(posedge clk);
      #1;
`endif
      @(negedge clk);
      chk({tag, "_err_pulse_end"}, {31'd0, err}, 32'd0);
      chk({tag, "_idle_stall"}, {31'd0, stallreq}, 32'd0);
      @(posedge clk);
      #1;
   endtask
   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_stall", {31'd0, stallreq}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("idle_rdata", rdata, 32'h0);
         chk("idle_stall", {31'd0, stallreq}, 32'd0);
         chk("idle_err", {31'd0, err}, 32'd0);
         @(posedge clk);
         #1;
      end
      access("wr_full", 32'h10, 4'hF, 32'hDEADBEEF);
      access("wr_lane1", 32'h10, 4'b0010, 32'h0000_5500);
      access("rd_10", 32'h10, 4'h0, 32'h0);
      chk("rd_10_value", rdata, 32'hDEAD55EF);
      access("wr_14_keep", 32'h14, 4'hF, 32'h0BAD_F00D);
      chk("rdata_held", rdata, 32'hDEAD55EF);
      access("wr_w0", 32'h0, 4'hF, 32'hA5A5_0001);
      access("wr_oor", 32'h8000_0000, 4'hF, 32'hFFFF_FFFF);
      access("rd_w0", 32'h0, 4'h0, 32'h0);
      access("rd_oor", 32'h8000_0000, 4'h0, 32'h0);
      access("wr_20", 32'h20, 4'hF, 32'hCAFE_F00D);
      access("rd_20_pre", 32'h20, 4'h0, 32'h0);
`ifdef DSRAM_WAIT_STATE_EN
      en    = 1'b1;
      addr  = 32'h20;
      wen   = 4'hF;
      wdata = 32'h1234_5678;
      @(posedge clk);
      #1;
      rst = 1'b1;
      en  = 1'b0;
`else
      rst   = 1'b1;
      en    = 1'b1;
      addr  = 32'h20;
      wen   = 4'hF;
      wdata = 32'h1234_5678;
`endif
      @(negedge clk);
      chk("midrst_stall", {31'd0, stallreq}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      en  = 1'b0;
      last_rdata = 32'h0;
      @(negedge clk);
      chk("postrst_rdata", rdata, 32'h0);
      chk("postrst_stall", {31'd0, stallreq}, 32'd0);
      @(posedge clk);
      #1;
      access("rd_20_post", 32'h20, 4'h0, 32'h0);
      for (int i = 0; i < 4; i++) access("rnd_init", 32'h100 + 32'(4 * i), 4'hF, $urandom);
      for (int i = 0; i < 12; i++) begin
         logic [31:0] a;
         a = 32'h100 + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3));
         access("rnd", a, 4'($urandom_range(0, 15)), $urandom);
      end
      chk("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/dsram_responder.md
# dsram_responder

Data-side SRAM responder: the target end of the data SRAM request interface driven by the execute stage (`data_sram_en`/`wen`/`addr`/`wdata`). It owns a word-organised local data memory, commits byte-lane writes, and returns registered read data to the memory stage. It optionally inserts programmable wait states, requesting a pipeline stall via `stallreq`.

## Interface
- `ADDR_W`, default 12: word-address bits; memory depth is 2^ADDR_W words (16 KB at default).
- `BASE_ADDR`, default 32'h0000_0000: region base; only bits [31:ADDR_W+2] are compared.
- `WAIT_CYCLES`, default 2: wait states per access, used only with the macro; must be ≥1.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `data_sram_en` in 1: request valid.
- `data_sram_wen` in 4: byte-lane write mask; 0 means read.
- `data_sram_addr` in 32: byte address.
- `data_sram_wdata` in 32: write data; lane i is bits [8i+7:8i].
- `data_sram_rdata` out 32: registered read data.
- `stallreq` out 1: freeze EX and earlier stages this cycle.
- `err` out 1: one-cycle pulse for an out-of-range access.

## Operation
- Word index = `addr[ADDR_W+1:2]`. `addr[1:0]` is ignored for indexing. Lane selection is by `wen` only.
- In range: `addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]`.
- Write (`wen != 0`): each lane with `wen[i]=1` takes `wdata` lane i. Other lanes are unchanged.
- Read (`wen == 0`): `rdata` loads the full word. `rdata` holds until the next read completes; writes never change it.
- Out-of-range access:
  - write is dropped;
  - read loads `rdata` = 0;
  - `err` pulses high the cycle after the access is performed.
- The array is single-port, so there is no simultaneous read/write.
- FSM (macro defined), states IDLE, WAIT, DONE:
  - IDLE: if `en`, accept the request. Latch addr, wen and wdata, load `cnt = WAIT_CYCLES`, go to WAIT. Assert `stallreq` combinationally in this cycle.
  - WAIT: `stallreq = 1`. Decrement `cnt` each cycle. At the end of the cycle with `cnt == 1`, perform the access from the latched copy and go to DONE.
  - DONE: `stallreq = 0`. Inputs are ignored, because the still-present held request is the same one. Return to IDLE next cycle.

## Timing
- Reset values: state IDLE, `cnt` 0, `rdata` 32'h0, `err` 0. `stallreq` is forced 0 while `rst`. Memory contents are not reset.
- Reset mid-operation: the latched request is discarded and the write is not committed. The next cycle is IDLE.
- With macro, for acceptance at cycle T0 and W = WAIT_CYCLES:
  - `stallreq` = 1 during T0..TW;
  - access is performed at the end of TW;
  - `rdata`/`err` are valid from T(W+1), the DONE cycle;
  - EX advances at the end of T(W+1). Extra stall is W+1 cycles.
- Back-to-back: the next request is acceptable at T(W+2) at the earliest.
- `en` deasserted in IDLE: no state change, `stallreq` = 0.

## Configuration
- `DSRAM_WAIT_STATE_EN` defined: the FSM, `cnt` and latched request are built, and timing is as above.
- `DSRAM_WAIT_STATE_EN` undefined:
  - no FSM; `stallreq` is tied 0 and `WAIT_CYCLES` is ignored;
  - the access is performed at the end of the acceptance cycle;
  - `rdata`/`err` are valid the next cycle, when the instruction is in MEM.

## Structure
- Package `dsram_pkg`:
  - state enum (IDLE/WAIT/DONE);
  - `DSRAM_LANES = 4`;
  - a lane-merge function (old word, new word, mask → merged word);
  - range-check function.
- Sub-module `dsram_array`: 2^ADDR_W × 32 memory with byte-lane write enable and registered read port. The responder wraps it with the range check, FSM and `err`.

## Test plan
- Reset, then idle: `rdata` = 0, `stallreq` = 0, `err` = 0. `en` = 0 for 10 cycles → no state change.
- Lane writes, then read (no macro):
  - write 32'hDEADBEEF to 0x10 with `wen` = 4'hF;
  - write 32'h0000_5500 to 0x10 with `wen` = 4'b0010;
  - read 0x10 → `rdata` = 32'hDEAD55EF one cycle after acceptance.
- Wait states (macro defined, `WAIT_CYCLES` = 2), read 0x10 held on inputs:
  - `stallreq` high for exactly 3 cycles, low in DONE;
  - `rdata` valid in DONE;
  - the held request is not re-accepted.
- Out of range: `BASE_ADDR` = 0, write to 0x8000_0000 → `err` pulses one cycle. A following read of word 0 returns the prior contents; a read of 0x8000_0000 returns 0 with `err`.
- Reset mid-access (macro defined): assert `rst` in WAIT during a write of 32'h1234_5678 to 0x20 → the later read of 0x20 returns the old value; `stallreq` = 0 during reset.
- Write does not disturb `rdata`: read 0x10 (0xDEAD55EF), then write 0x14 → `rdata` stays 32'hDEAD55EF.
